// File: rtl/vs_util_pkg.sv
// Shared types for the sparse-recovery datapath: processor command, raw fp32 word,
// sweep-sequencer state encoding and read-mux select values.
package vs_util;

  typedef enum logic [1:0] {
    LOAD_SENSING_MATRIX    = 2'd0,
    COMPUTE_INNER_PRODUCTS = 2'd1
  } vs_sensing_matrix_command_t;

  typedef logic [31:0] fp_32_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    L_SETUP  = 3'd1,
    L_START  = 3'd2,
    L_STREAM = 3'd3,
    S_START  = 3'd4,
    S_WAIT   = 3'd5,
    M_WAIT   = 3'd6,
    CAPTURE  = 3'd7
  } vs_sweep_seq_state_t;

  localparam logic SEL_RESIDUAL = 1'b0;
  localparam logic SEL_PHI      = 1'b1;

endpackage

// File: rtl/vs_sweep_sequencer_watchdog.sv
// Generic wait-state watchdog: clear restarts the count, enable advances it, and
// expired_o is high in the LIMIT-th enabled cycle after a clear. LIMIT = 0 disables it.
module vs_watchdog_counter #(
  parameter int unsigned LIMIT = 4096,
  parameter int unsigned CNT_W = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] LAST = (LIMIT == 0) ? '0 : CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign expired_o = (LIMIT != 0) && enable_i && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear_i)
      count_d = '0;
    else if (enable_i && !expired_o)
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/vs_sweep_sequencer.sv
// Correlation-step controller: loads phi into the processor, runs the inner-product
// sweep, waits for the max identifier and reports the captured location/value.
// Handshake: load_req/sweep_req are level-sampled only in IDLE (busy=0) and dropped
// otherwise; result_valid is a one-cycle pulse with result_* held until the next one.
module vs_sweep_sequencer
  import vs_util::*;
#(
  parameter int unsigned ROWS           = 4,
  parameter int unsigned COLUMNS        = 8,
  parameter int unsigned PHI_ADDR_WIDTH = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       load_req,
  input  logic                       sweep_req,
  output logic                       busy,
  output logic                       matrix_loaded,
  output vs_sensing_matrix_command_t proc_command,
  output logic                       proc_start,
  input  logic                       proc_done,
  output logic                       proc_read_select,
  output logic [PHI_ADDR_WIDTH-1:0]  phi_read_addr,
  input  logic                       max_batch_done,
  input  logic [7:0]                 max_location,
  input  fp_32_t                     max_value,
  output logic                       result_valid,
  output logic [7:0]                 result_location,
  output fp_32_t                     result_value,
  output logic                       error,
  output logic [7:0]                 sweep_count,
  output vs_sweep_seq_state_t        state_dbg
);

  localparam logic [PHI_ADDR_WIDTH-1:0] ADDR_LAST = PHI_ADDR_WIDTH'(ROWS * COLUMNS - 1);

  vs_sweep_seq_state_t        state_q, state_d;
  vs_sensing_matrix_command_t cmd_q, cmd_d;
  logic                       sel_q, sel_d;
  logic [PHI_ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                       loaded_q, loaded_d;
  logic                       max_seen_q, max_seen_d;
  logic [7:0]                 pend_loc_q, pend_loc_d, res_loc_q, res_loc_d;
  fp_32_t                     pend_val_q, pend_val_d, res_val_q, res_val_d;
  logic [7:0]                 count_q, count_d;
  logic                       wd_clear, wd_enable, wd_expired;
  logic                       max_hit;

  // The max unit may finish before or together with proc_done; either counts.
  assign max_hit = max_seen_q | max_batch_done;

  vs_watchdog_counter #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk_i     (clock),
    .rst_i     (reset),
    .clear_i   (wd_clear),
    .enable_i  (wd_enable),
    .expired_o (wd_expired)
  );

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    sel_d        = sel_q;
    addr_d       = addr_q;
    loaded_d     = loaded_q;
    max_seen_d   = max_seen_q;
    pend_loc_d   = pend_loc_q;
    pend_val_d   = pend_val_q;
    res_loc_d    = res_loc_q;
    res_val_d    = res_val_q;
    count_d      = count_q;
    proc_start   = 1'b0;
    result_valid = 1'b0;
    error        = 1'b0;
    wd_clear     = 1'b0;
    wd_enable    = 1'b0;
    if ((state_q == S_WAIT || state_q == M_WAIT) && max_batch_done) begin
      max_seen_d = 1'b1;
      pend_loc_d = max_location;
      pend_val_d = max_value;
    end
    case (state_q)
      IDLE: begin
        if (load_req) begin
          state_d  = L_SETUP;
          sel_d    = SEL_PHI;
          cmd_d    = LOAD_SENSING_MATRIX;
          addr_d   = '0;
          loaded_d = 1'b0;
        end else if (sweep_req) begin
          if (loaded_q) begin
            state_d = S_START;
            sel_d   = SEL_RESIDUAL;
            cmd_d   = COMPUTE_INNER_PRODUCTS;
          end else begin
            error = 1'b1;
          end
        end
      end
      L_SETUP: state_d = L_START;
      L_START: begin
        proc_start = 1'b1;
        wd_clear   = 1'b1;
        addr_d     = (addr_q == ADDR_LAST) ? addr_q : addr_q + 1'b1;
        state_d    = L_STREAM;
      end
      L_STREAM: begin
        wd_enable = 1'b1;
        if (addr_q != ADDR_LAST) addr_d = addr_q + 1'b1;
        if (proc_done) begin
          state_d  = IDLE;
          loaded_d = 1'b1;
        end else if (wd_expired) begin
          state_d = IDLE;
          error   = 1'b1;
        end
      end
      S_START: begin
        proc_start = 1'b1;
        max_seen_d = 1'b0;
        wd_clear   = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT, M_WAIT: begin
        wd_enable = 1'b1;
        if ((state_q == S_WAIT) ? (proc_done && max_hit) : max_hit) begin
          state_d   = CAPTURE;
          res_loc_d = max_batch_done ? max_location : pend_loc_q;
          res_val_d = max_batch_done ? max_value    : pend_val_q;
        end else if (state_q == S_WAIT && proc_done) begin
          state_d  = M_WAIT;
          wd_clear = 1'b1;
        end else if (wd_expired) begin
          state_d = IDLE;
          error   = 1'b1;
        end
      end
      CAPTURE: begin
        result_valid = 1'b1;
        count_d      = count_q + 8'd1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cmd_q      <= LOAD_SENSING_MATRIX;
      sel_q      <= SEL_RESIDUAL;
      addr_q     <= '0;
      loaded_q   <= 1'b0;
      max_seen_q <= 1'b0;
      pend_loc_q <= '0;
      pend_val_q <= '0;
      res_loc_q  <= '0;
      res_val_q  <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      loaded_q   <= loaded_d;
      max_seen_q <= max_seen_d;
      pend_loc_q <= pend_loc_d;
      pend_val_q <= pend_val_d;
      res_loc_q  <= res_loc_d;
      res_val_q  <= res_val_d;
      count_q    <= count_d;
    end
  end

  assign busy             = (state_q != IDLE);
  assign matrix_loaded    = loaded_q;
  assign proc_command     = cmd_q;
  assign proc_read_select = sel_q;
  assign phi_read_addr    = addr_q;
  assign result_location  = res_loc_q;
  assign result_value     = res_val_q;
  assign sweep_count      = count_q;
  assign state_dbg        = state_q;

endmodule

// File: tb/tb_vs_sweep_sequencer.sv
// Bench for vs_sweep_sequencer: directed load/sweep/watchdog/reset scenarios plus
// random phi/residual rounds, with a processor/max-identifier model around the DUT.
module tb_vs_sweep_sequencer;
  import vs_util::*;

  localparam int ROWS = 4;
  localparam int COLS = 8;
  localparam int N    = ROWS * COLS;
  localparam int AW   = 16;
  localparam int WD   = 40;

  logic                       clock = 1'b0;
  logic                       reset;
  logic                       load_req, sweep_req, proc_done, max_batch_done;
  logic [7:0]                 max_location;
  fp_32_t                     max_value;
  logic                       busy, matrix_loaded, proc_start, proc_read_select;
  logic                       result_valid, error;
  vs_sensing_matrix_command_t proc_command;
  logic [AW-1:0]              phi_read_addr;
  logic [7:0]                 result_location, sweep_count;
  fp_32_t                     result_value;
  vs_sweep_seq_state_t        state_dbg;

  int tests = 0;
  int fails = 0;
  int exp_sweeps = 0;
  int start_pulses = 0;
  int load_idx = -1;
  logic [39:0] exp_q[$];
  int phi_ram[N];
  int phi_loaded[N];
  int residual[ROWS];
  logic [3:0] col_pat[COLS] = '{4'hF, 4'h3, 4'hF, 4'hC, 4'h7, 4'hB, 4'hD, 4'h7};

  vs_sweep_sequencer #(
    .ROWS(ROWS), .COLUMNS(COLS), .PHI_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(WD)
  ) uut (
    .clock(clock), .reset(reset), .load_req(load_req), .sweep_req(sweep_req),
    .busy(busy), .matrix_loaded(matrix_loaded), .proc_command(proc_command),
    .proc_start(proc_start), .proc_done(proc_done), .proc_read_select(proc_read_select),
    .phi_read_addr(phi_read_addr), .max_batch_done(max_batch_done),
    .max_location(max_location), .max_value(max_value), .result_valid(result_valid),
    .result_location(result_location), .result_value(result_value), .error(error),
    .sweep_count(sweep_count), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] to_fp(input int v);
    int a, m;
    logic [31:0] r;
    if (v == 0) return 32'h0;
    a = (v < 0) ? -v : v;
    m = 0;
    for (int i = 0; i < 31; i++) if ((a >> i) != 0) m = i;
    r[31]    = (v < 0);
    r[30:23] = 8'(127 + m);
    r[22:0]  = 23'((a << (23 - m)) & 32'h7fffff);
    return r;
  endfunction

  // Argmax (first occurrence) of phi^T * residual, as {location, fp32 value}.
  function automatic logic [39:0] max_of(input int mat[N]);
    int prod[COLS];
    int best;
    best = 0;
    for (int c = 0; c < COLS; c++) begin
      prod[c] = 0;
      for (int r = 0; r < ROWS; r++) prod[c] += mat[r * COLS + c] * residual[r];
      if (prod[c] > prod[best]) best = c;
    end
    return {8'(best), to_fp(prod[best])};
  endfunction

  // Processor model: after a load start it stores one RAM word per cycle, in order.
  always @(negedge clock) begin
    if (reset) load_idx = -1;
    else begin
      if (proc_start) start_pulses++;
      if (proc_start && proc_command == LOAD_SENSING_MATRIX) load_idx = 0;
      if (load_idx >= 0 && load_idx < N) begin
        phi_loaded[load_idx] = (int'(phi_read_addr) < N) ? phi_ram[phi_read_addr] : 99;
        load_idx++;
      end
    end
  end

  // Scoreboard: every result pulse must match the oldest expected result.
  always @(negedge clock) begin : result_mon
    logic [39:0] e;
    if (!reset && result_valid) begin
      if (exp_q.size() == 0) check("unexpected_result", 40'd1, 40'd0);
      else begin
        e = exp_q.pop_front();
        check("result", {result_location, result_value}, e);
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_load(input bit collide, input bit timeout);
    int bad;
    int last;
    last = timeout ? WD : N - 1;
    load_req = 1'b1; sweep_req = collide;
    @(negedge clock); check("load_req_cycle", {busy, error}, 2'b00);
    cyc(); load_req = 1'b0; sweep_req = 1'b0;
    @(negedge clock);
    check("l_setup", {busy, proc_start, proc_read_select, matrix_loaded, proc_command, 8'(phi_read_addr)},
          {1'b1, 1'b0, 1'b1, 1'b0, LOAD_SENSING_MATRIX, 8'd0});
    cyc();
    @(negedge clock); check("l_start", {busy, proc_start, 8'(phi_read_addr)}, {1'b1, 1'b1, 8'd0});
    for (int k = 1; k <= last; k++) begin
      cyc();
      proc_done = !timeout && (k == N - 1);
      load_req  = 1'($urandom_range(0, 1));
      sweep_req = 1'($urandom_range(0, 1));
      @(negedge clock);
      check("l_stream", {busy, proc_start, error, 8'(phi_read_addr)},
            {1'b1, 1'b0, 1'(timeout && k == WD), 8'((k < N) ? k : N - 1)});
    end
    cyc(); proc_done = 1'b0; load_req = 1'b0; sweep_req = 1'b0;
    @(negedge clock);
    check("load_end", {busy, error, matrix_loaded}, {1'b0, 1'b0, !timeout});
    if (!timeout) begin
      bad = 0;
      for (int i = 0; i < N; i++) if (phi_loaded[i] != phi_ram[i]) bad++;
      check("phi_copy", 40'(bad), 40'd0);
    end
  endtask

  // pd: S_WAIT cycle carrying proc_done; mo: max_batch_done offset from it.
  task automatic do_sweep(input int pd, input int mo);
    logic [39:0] drv;
    int m, last;
    m    = pd + mo;
    last = (m > pd) ? m : pd;
    exp_q.push_back(max_of(phi_ram));
    drv = max_of(phi_loaded);
    sweep_req = 1'b1;
    @(negedge clock); check("sweep_req_cycle", {busy, error}, 2'b00);
    cyc(); sweep_req = 1'b0;
    @(negedge clock);
    check("s_start", {busy, proc_start, proc_read_select, proc_command},
          {1'b1, 1'b1, 1'b0, COMPUTE_INNER_PRODUCTS});
    for (int i = 1; i <= last; i++) begin
      cyc();
      proc_done      = (i == pd);
      max_batch_done = (i == m);
      {max_location, max_value} = (i == m) ? drv : {8'($urandom), 32'($urandom)};
      load_req  = 1'($urandom_range(0, 1));
      sweep_req = 1'($urandom_range(0, 1));
      @(negedge clock); check("sweep_wait", {busy, proc_start, result_valid, error}, 4'b1000);
    end
    cyc();
    proc_done = 1'b0; max_batch_done = 1'b0; load_req = 1'b0; sweep_req = 1'b0;
    {max_location, max_value} = {8'($urandom), 32'($urandom)};
    @(negedge clock); check("capture", {busy, result_valid}, 2'b11);
    exp_sweeps++;
    cyc();
    @(negedge clock);
    check("after_sweep", {busy, result_valid, sweep_count}, {1'b0, 1'b0, 8'(exp_sweeps)});
  endtask

  initial begin
    int pd;
    reset = 1'b1;
    {load_req, sweep_req, proc_done, max_batch_done} = 4'b0;
    max_location = 8'd0; max_value = 32'd0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_outputs",
          {busy, matrix_loaded, proc_start, proc_read_select, result_valid, error, proc_command,
           sweep_count, result_location, 8'(phi_read_addr)}, 40'd0);
    check("reset_value", 40'(result_value), 40'd0);
    reset = 1'b0;

    // sweep before any load
    sweep_req = 1'b1;
    @(negedge clock); check("early_sweep_err", {busy, error}, 2'b01);
    cyc(); sweep_req = 1'b0;
    @(negedge clock); check("early_sweep_after", {busy, error, 8'(start_pulses)}, {1'b0, 1'b0, 8'd0});

    // directed phi and residual {1,2,-2,1}
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) phi_ram[r * COLS + c] = col_pat[c][r] ? 1 : -1;
    cyc(); do_load(1'b0, 1'b0);
    residual = '{1, 2, -2, 1};
    cyc(); do_sweep(3, 1);
    check("spec_result", {result_location, result_value}, {8'd5, 32'h40C00000});
    check("spec_count", 40'(sweep_count), 40'd1);
    cyc(); do_sweep(5, -3);
    cyc(); do_sweep(4, 0);

    // random rounds
    for (int n = 0; n < 5; n++) begin
      for (int i = 0; i < N; i++) phi_ram[i] = $urandom_range(0, 1) ? 1 : -1;
      cyc(); do_load(1'b0, 1'b0);
      for (int s = 0; s < 3; s++) begin
        for (int r = 0; r < ROWS; r++) residual[r] = int'($urandom_range(0, 16)) - 8;
        pd = int'($urandom_range(1, 8));
        cyc(); do_sweep(pd, int'($urandom_range(0, pd + 3)) - (pd - 1));
      end
    end

    // watchdog during a load
    cyc(); do_load(1'b0, 1'b1);
    sweep_req = 1'b1;
    @(negedge clock); check("sweep_after_timeout", {busy, error}, 2'b01);
    cyc(); sweep_req = 1'b0;

    // reset during S_WAIT
    cyc(); do_load(1'b0, 1'b0);
    cyc(); sweep_req = 1'b1;
    cyc(); sweep_req = 1'b0;
    cyc();
    @(posedge clock); #3; reset = 1'b1; #1;
    check("async_reset",
          {busy, matrix_loaded, proc_start, proc_read_select, result_valid, error, proc_command,
           sweep_count, result_location, 8'(phi_read_addr)}, 40'd0);
    check("async_reset_value", 40'(result_value), 40'd0);
    cyc(); reset = 1'b0; exp_sweeps = 0;
    @(negedge clock); check("post_reset_idle", {busy, result_valid}, 2'b00);

    // load and sweep requested together: load only
    cyc(); do_load(1'b1, 1'b0);
    check("collision_count", 40'(sweep_count), 40'd0);
    check("queue_drained", 40'(exp_q.size()), 40'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
